reg_alu_sequencer: RTL and testbench

//  Parametrised execute unit: register file plus FSM that sequences read -> ALU -> write-back per instruction.

---
 rtl/reg_alu_sequencer_pkg.sv | 15 +
 rtl/reg_alu_sequencer_reg_file.sv | 32 +++
 rtl/reg_alu_sequencer.sv | 106 ++++++++++
 tb/tb_reg_alu_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_alu_sequencer_pkg.sv
// reg_alu_sequencer_pkg: opcodes, FSM states and address-width helper shared by the execute unit
package reg_alu_sequencer_pkg;
  localparam int OP_LOADI = 0;
  localparam int OP_ADD   = 1;
  localparam int OP_SUB   = 2;
  localparam int OP_MUL   = 3;
  localparam int OP_DIV   = 4;
  localparam int OP_FADD  = 5;
  localparam int OP_FMUL  = 6;
  localparam int OP_CMP   = 7;
  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_e;
  function automatic int addr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/reg_alu_sequencer_reg_file.sv
// reg_file_2r1w: two operand read ports plus a debug read, one synchronous write, async clear
module reg_file_2r1w
  import reg_alu_sequencer_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int NUM_REGS = 8,
  localparam int AW      = addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [AW-1:0]     ra_a_i,
  input  logic [AW-1:0]     ra_b_i,
  input  logic [AW-1:0]     ra_d_i,
  output logic [DATA_W-1:0] rd_a_o,
  output logic [DATA_W-1:0] rd_b_o,
  output logic [DATA_W-1:0] rd_d_o
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < (AW+1)'(NUM_REGS);
  endfunction
  // Addresses past NUM_REGS read as zero and silently drop writes
  assign rd_a_o = in_range(ra_a_i) ? regs_q[ra_a_i] : '0;
  assign rd_b_o = in_range(ra_b_i) ? regs_q[ra_b_i] : '0;
  assign rd_d_o = in_range(ra_d_i) ? regs_q[ra_d_i] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) regs_q <= '{default: '0};
    else if (we_i && in_range(wa_i)) regs_q[wa_i] <= wd_i;
endmodule

// File: rtl/reg_alu_sequencer.sv
// reg_alu_sequencer: register file plus FSM sequencing read -> external ALU -> write-back per instruction
module reg_alu_sequencer
  import reg_alu_sequencer_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int NUM_REGS = 8,
  parameter int OP_W     = 3,
  parameter int ALU_LAT  = 0,
  localparam int AW      = addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [AW-1:0]     instr_rd,
  input  logic [AW-1:0]     instr_rs1,
  input  logic [AW-1:0]     instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic              busy,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  state_e            state_q;
  logic [OP_W-1:0]   op_q, alu_op_q;
  logic [AW-1:0]     rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0] imm_q, res_q, alu_a_q, alu_b_q, rd_a, rd_b, wd_d;
  logic [3:0]        cnt_q;
  logic              done_q, busy_q, ready_q, is_loadi;
  assign is_loadi    = op_q == OP_W'(OP_LOADI);
  assign wd_d        = is_loadi ? imm_q : res_q;
  assign instr_ready = ready_q;
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign done        = done_q;
  assign busy        = busy_q;
  reg_file_2r1w #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we_i   (state_q == WRITE),
    .wa_i   (rd_q),
    .wd_i   (wd_d),
    .ra_a_i (rs1_q),
    .ra_b_i (rs2_q),
    .ra_d_i (dbg_addr),
    .rd_a_o (rd_a),
    .rd_b_o (rd_b),
    .rd_d_o (dbg_data)
  );
  // done/busy/ready are registered from the next state so they line up with it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (instr_valid && ready_q) begin
          op_q    <= instr_op;
          rd_q    <= instr_rd;
          rs1_q   <= instr_rs1;
          rs2_q   <= instr_rs2;
          imm_q   <= instr_imm;
          state_q <= instr_op == OP_W'(OP_LOADI) ? WRITE : READ;
          done_q  <= instr_op == OP_W'(OP_LOADI);
          busy_q  <= 1'b1;
          ready_q <= 1'b0;
        end
        READ: begin
          alu_a_q  <= rd_a;
          alu_b_q  <= rd_b;
          alu_op_q <= op_q;
          cnt_q    <= '0;
          state_q  <= EXEC;
        end
        EXEC: if (cnt_q == 4'(ALU_LAT)) begin
          res_q   <= alu_result;
          state_q <= WRITE;
          done_q  <= 1'b1;
        end else cnt_q <= cnt_q + 4'd1;
        WRITE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_reg_alu_sequencer.sv
// tb_reg_alu_sequencer: three builds (default, ALU_LAT=3, NUM_REGS=6) driven by directed vectors, scoreboard-checked
module tb_reg_alu_sequencer;
  localparam int N = 3;
  typedef struct packed {int cyc; logic [2:0] rd; logic [11:0] val;} exp_t;
  logic        clk = 1'b0;
  logic        rst [N];
  logic        instr_valid [N], instr_ready [N], done [N], busy [N];
  logic [2:0]  instr_op [N], instr_rd [N], instr_rs1 [N], instr_rs2 [N], alu_op [N], dbg_addr [N];
  logic [11:0] instr_imm [N], alu_a [N], alu_b [N], alu_result [N], dbg_data [N];
  logic [26:0] snap [N];
  time         chg_t [N];
  exp_t        dq [N][$];
  exp_t        pq [N][$];
  logic        pend [N];
  logic [11:0] pval [N];
  int cyc = 0;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  reg_alu_sequencer u0 (
    .clk(clk), .rst(rst[0]), .instr_valid(instr_valid[0]), .instr_ready(instr_ready[0]),
    .instr_op(instr_op[0]), .instr_rd(instr_rd[0]), .instr_rs1(instr_rs1[0]), .instr_rs2(instr_rs2[0]),
    .instr_imm(instr_imm[0]), .alu_op(alu_op[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
    .alu_result(alu_result[0]), .done(done[0]), .busy(busy[0]), .dbg_addr(dbg_addr[0]), .dbg_data(dbg_data[0]));
  reg_alu_sequencer #(.ALU_LAT(3)) u1 (
    .clk(clk), .rst(rst[1]), .instr_valid(instr_valid[1]), .instr_ready(instr_ready[1]),
    .instr_op(instr_op[1]), .instr_rd(instr_rd[1]), .instr_rs1(instr_rs1[1]), .instr_rs2(instr_rs2[1]),
    .instr_imm(instr_imm[1]), .alu_op(alu_op[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
    .alu_result(alu_result[1]), .done(done[1]), .busy(busy[1]), .dbg_addr(dbg_addr[1]), .dbg_data(dbg_data[1]));
  reg_alu_sequencer #(.NUM_REGS(6)) u2 (
    .clk(clk), .rst(rst[2]), .instr_valid(instr_valid[2]), .instr_ready(instr_ready[2]),
    .instr_op(instr_op[2]), .instr_rd(instr_rd[2]), .instr_rs1(instr_rs1[2]), .instr_rs2(instr_rs2[2]),
    .instr_imm(instr_imm[2]), .alu_op(alu_op[2]), .alu_a(alu_a[2]), .alu_b(alu_b[2]),
    .alu_result(alu_result[2]), .done(done[2]), .busy(busy[2]), .dbg_addr(dbg_addr[2]), .dbg_data(dbg_data[2]));
  function automatic int lat(input int k);
    return k == 1 ? 3 : 0;
  endfunction
  // 12-bit float: sign, 5-bit exponent, 6-bit mantissa with hidden one; positive operands only
  function automatic logic [11:0] fadd(input logic [11:0] x, input logic [11:0] y);
    logic [11:0] a, b;
    logic [7:0]  s;
    a = x[10:0] < y[10:0] ? y : x;
    b = x[10:0] < y[10:0] ? x : y;
    s = {2'b01, a[5:0]} + ({2'b01, b[5:0]} >> (a[10:6] - b[10:6]));
    return s[7] ? {a[11], a[10:6] + 5'd1, s[6:1]} : {a[11], a[10:6], s[5:0]};
  endfunction
  function automatic logic [11:0] alu_f(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b);
    case (op)
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a * b;
      3'd4: return b == 12'd0 ? 12'hFFF : a / b;
      3'd5: return fadd(a, b);
      3'd7: return {11'd0, a < b};
      default: return a ^ b;
    endcase
  endfunction
  // ALU model: output is garbage until operands have been stable for lat(k) cycles
  always @(negedge clk)
    for (int k = 0; k < N; k++) begin
      snap[k]       <= {alu_op[k], alu_a[k], alu_b[k]};
      chg_t[k]      <= snap[k] !== {alu_op[k], alu_a[k], alu_b[k]} ? $time : chg_t[k];
      alu_result[k] <= ((snap[k] !== {alu_op[k], alu_a[k], alu_b[k]}) ? 0 : $time - chg_t[k]) >= time'(lat(k) * 10)
                       ? alu_f(alu_op[k], alu_a[k], alu_b[k]) : 12'hBAD;
    end
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endfunction
  // Monitor: on each done pop the expected write, check its cycle, then read it back via dbg
  initial begin
    exp_t e;
    for (int k = 0; k < N; k++) begin
      dbg_addr[k] = 3'd0;
      pend[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (pend[k]) begin
          chk($sformatf("u%0d dbg r%0d", k, dbg_addr[k]), 32'(dbg_data[k]), 32'(pval[k]));
          pend[k] = 1'b0;
        end
        if (done[k] === 1'b1) begin
          if (dq[k].size() == 0) chk($sformatf("u%0d unexpected done", k), 32'd1, 32'd0);
          else begin
            e = dq[k].pop_front();
            chk($sformatf("u%0d done cycle r%0d", k, e.rd), 32'(cyc), 32'(e.cyc));
            dbg_addr[k] = e.rd;
            pval[k] = e.val;
            pend[k] = 1'b1;
          end
        end else if (!pend[k] && pq[k].size() != 0) begin
          e = pq[k].pop_front();
          dbg_addr[k] = e.rd;
          pval[k] = e.val;
          pend[k] = 1'b1;
        end
      end
    end
  end
  task automatic issue(input int k, input int op, input int rd, input int rs1, input int rs2,
                       input int imm, input int expv, input bit exp_done, output int waits);
    waits = 0;
    @(negedge clk);
    instr_op[k] = 3'(op);
    instr_rd[k] = 3'(rd);
    instr_rs1[k] = 3'(rs1);
    instr_rs2[k] = 3'(rs2);
    instr_imm[k] = 12'(imm);
    instr_valid[k] = 1'b1;
    while (instr_ready[k] !== 1'b1 && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 40) chk($sformatf("u%0d accept timeout", k), 32'd0, 32'd1);
    else if (exp_done) dq[k].push_back('{cyc: cyc + 1 + (op == 0 ? 0 : 2 + lat(k)), rd: 3'(rd), val: 12'(expv)});
    @(negedge clk);
    instr_valid[k] = 1'b0;
  endtask
  task automatic probe(input int k, input int r, input int v);
    pq[k].push_back('{cyc: 0, rd: 3'(r), val: 12'(v)});
  endtask
  task automatic drain(input int k);
    int n = 0;
    while ((pend[k] || pq[k].size() != 0 || dq[k].size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk($sformatf("u%0d drain timeout", k), 32'd0, 32'd1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int w, n;
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b0;
      instr_valid[k] = 1'b0;
      instr_op[k] = 3'd0;
      instr_rd[k] = 3'd0;
      instr_rs1[k] = 3'd0;
      instr_rs2[k] = 3'd0;
      instr_imm[k] = 12'd0;
    end
    #2;
    for (int k = 0; k < N; k++) rst[k] = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("u%0d reset ready", k), 32'(instr_ready[k]), 32'd1);
      chk($sformatf("u%0d reset busy", k), 32'(busy[k]), 32'd0);
      chk($sformatf("u%0d reset done", k), 32'(done[k]), 32'd0);
      chk($sformatf("u%0d reset alu_a", k), 32'(alu_a[k]), 32'd0);
      chk($sformatf("u%0d reset alu_op", k), 32'(alu_op[k]), 32'd0);
    end
    issue(0, 0, 0, 0, 0, 100, 100, 1, w);
    issue(0, 0, 1, 0, 0, 2, 2, 1, w);
    issue(0, 0, 5, 0, 0, 'h440, 'h440, 1, w);
    issue(0, 0, 6, 0, 0, 'h440, 'h440, 1, w);
    drain(0);
    issue(0, 1, 2, 0, 1, 0, 102, 1, w);
    @(negedge clk);
    chk("u0 exec alu_a", 32'(alu_a[0]), 32'd100);
    chk("u0 exec alu_b", 32'(alu_b[0]), 32'd2);
    chk("u0 exec alu_op", 32'(alu_op[0]), 32'd1);
    @(negedge clk);
    chk("u0 write alu_a held", 32'(alu_a[0]), 32'd100);
    issue(0, 2, 3, 0, 1, 0, 98, 1, w);
    drain(0);
    chk("u0 idle alu_op kept", 32'(alu_op[0]), 32'd2);
    chk("u0 idle alu_b kept", 32'(alu_b[0]), 32'd2);
    issue(0, 5, 7, 5, 6, 0, 'h480, 1, w);
    chk("u0 ready low in read", 32'(instr_ready[0]), 32'd0);
    issue(0, 1, 2, 7, 0, 0, 'h4E4, 1, w);
    chk("u0 back-to-back waits", 32'(w), 32'd2);
    issue(0, 1, 1, 1, 1, 0, 4, 1, w);
    drain(0);
    issue(1, 0, 0, 0, 0, 100, 100, 1, w);
    issue(1, 0, 1, 0, 0, 2, 2, 1, w);
    issue(1, 3, 4, 0, 1, 0, 200, 1, w);
    n = 0;
    while (busy[1] === 1'b1 && n < 20) begin
      n++;
      instr_valid[1] = 1'b1;
      instr_op[1] = 3'd0;
      instr_rd[1] = 3'd4;
      instr_imm[1] = 12'hFFF;
      @(negedge clk);
    end
    instr_valid[1] = 1'b0;
    chk("u1 busy cycles", 32'(n), 32'd6);
    drain(1);
    issue(1, 1, 1, 1, 1, 0, 4, 1, w);
    drain(1);
    issue(0, 1, 2, 0, 1, 0, 0, 0, w);
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("u0 abort busy", 32'(busy[0]), 32'd0);
    chk("u0 abort alu_a", 32'(alu_a[0]), 32'd0);
    rst[0] = 1'b0;
    @(negedge clk);
    chk("u0 abort ready", 32'(instr_ready[0]), 32'd1);
    for (int r = 0; r < 8; r++) probe(0, r, 0);
    drain(0);
    issue(2, 0, 0, 0, 0, 100, 100, 1, w);
    issue(2, 0, 7, 0, 0, 'h123, 0, 1, w);
    issue(2, 0, 6, 0, 0, 'h55, 0, 1, w);
    drain(2);
    probe(2, 0, 100);
    for (int r = 1; r < 6; r++) probe(2, r, 0);
    drain(2);
    issue(2, 1, 1, 6, 0, 0, 100, 1, w);
    @(negedge clk);
    chk("u2 out-of-range alu_a", 32'(alu_a[2]), 32'd0);
    chk("u2 alu_b", 32'(alu_b[2]), 32'd100);
    drain(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
